bomb_ctrl: RTL and testbench
============================

BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 The module SHALL use one clock and one reset; the reset is synchronous and active-low.
REQ-002 Parameter STEP_FRAMES, default 30, sets the frames per fuse step.
REQ-003 Parameter BLAST_FRAMES, default 15, sets the frames the explosion is displayed.
REQ-004 Parameter BOMB_STOCK, default 6, sets the bombs available per level.
REQ-005 Parameter BLAST_RADIUS, default 40, sets the horizontal kill distance in pixels.
REQ-006 Port clk, input, 1 bit: system clock.
REQ-007 Port reset_n, input, 1 bit: synchronous active-low reset.
REQ-008 Port frame_tick, input, 1 bit: one-cycle pulse once per video frame.
REQ-009 Port active, input, 1 bit: the level is running.
REQ-010 Port level_start, input, 1 bit: one-cycle pulse that reloads the level.
REQ-011 Port f_key, input, 1 bit: drop-bomb key, a level signal that is already synchronised.
REQ-012 Port char_pos_x and char_pos_y, input, 10 bits each: character centre.
REQ-013 Port bomb_pos_x and bomb_pos_y, output, 10 bits each: bomb centre.
REQ-014 Port b_cnt, output, 4 bits: 0 = no bomb, 1..2 = fuse burning, 3 = exploding.
REQ-015 Port bombs_left, output, 3 bits: remaining stock.
REQ-016 Port char_hit, output, 1 bit: one-cycle pulse when the blast catches the character.

Function
REQ-017 The state machine SHALL have four states: IDLE, FUSE1, FUSE2, BLAST; b_cnt is 0, 1, 2 and 3 respectively.
REQ-018 f_key SHALL be rising-edge detected; a key held continuously produces exactly one drop request.
REQ-019 A drop SHALL be accepted only in IDLE with active=1 and bombs_left>0.
REQ-020 On acceptance, in the same cycle:
- latch bomb_pos_x = char_pos_x;
- latch bomb_pos_y = min(char_pos_y + 18, 464);
- decrement bombs_left;
- enter FUSE1.
b_cnt becomes 1 on the next cycle.
REQ-021 A frame counter SHALL count frame_tick pulses while in FUSE1, FUSE2 or BLAST; it clears on every state change.
REQ-022 State transitions on frame counts:
- FUSE1 -> FUSE2 after STEP_FRAMES ticks;
- FUSE2 -> BLAST after STEP_FRAMES ticks;
- BLAST -> IDLE after BLAST_FRAMES ticks.
REQ-023 Drop requests arriving outside IDLE SHALL be discarded, not queued.
REQ-024 On the FUSE2 -> BLAST transition, the hit check is evaluated once:
- |char_pos_x - bomb_pos_x| < BLAST_RADIUS, and
- |char_pos_y + 18 - bomb_pos_y| < 28.
Subtractions are 11-bit signed. When both hold, char_hit is pulsed on the next cycle.
REQ-025 bomb_pos_x and bomb_pos_y SHALL hold their value from acceptance until the next acceptance.
REQ-026 When active falls while not in IDLE, the bomb SHALL be aborted on the next cycle: IDLE, b_cnt=0, no char_hit; bombs_left is kept.
REQ-027 level_start SHALL force IDLE, set bombs_left=BOMB_STOCK and clear the frame counter.
REQ-028 level_start SHALL have priority over a drop, frame_tick and active in the same cycle.
REQ-029 A drop and a frame_tick in the same cycle in IDLE: the drop is accepted, and the tick is not counted.
REQ-030 bombs_left SHALL saturate at 0; it never wraps.

Reset
REQ-031 While reset_n=0 at a clock edge, all outputs SHALL take these values:
- state IDLE, b_cnt=0;
- bomb_pos_x=0, bomb_pos_y=0;
- bombs_left=BOMB_STOCK;
- char_hit=0;
- frame counter and edge-detect register = 0.
REQ-032 Reset asserted mid-fuse SHALL abandon the bomb with no char_hit pulse.

Structure
REQ-033 Shared package hero_pkg SHALL hold:
- screen limits 635/475;
- character half-sizes 13/28;
- bomb half-size 10;
- the bomb state enumeration.
REQ-034 The f_key edge detect SHALL be a sub-module named rise_detect.
REQ-035 All other logic SHALL be flat, with registered outputs only.

Verification
REQ-036 Defaults, active=1, char (300,200). Press f_key, then 30 ticks, 30 ticks, 15 ticks.
- Response: bomb_pos (300,218), bombs_left 5; b_cnt 1 -> 2 -> 3 -> 0 at tick 30/60/75; char_hit pulses once at BLAST entry.
REQ-037 Same drop, but char moved to x=400 before BLAST.
- Response: no char_hit. Also hold f_key high 200 frames: only one drop.
REQ-038 Six drop/explode cycles, then a seventh f_key press.
- Response: bombs_left 0, b_cnt stays 0; after level_start, bombs_left 6.
REQ-039 Drop, then active=0 at FUSE2.
- Response: b_cnt 0 next cycle, no char_hit, bombs_left unchanged.
REQ-040 char_pos_y=460 drop gives bomb_pos_y=464. Same-cycle level_start and f_key edge gives IDLE with bombs_left=6.
REQ-041 reset_n=0 during BLAST gives all outputs at reset values on the next edge, with no char_hit.

Source files
------------

// File: rtl/hero_pkg.sv
// hero_pkg: screen/sprite geometry and bomb state encoding shared by the hero game blocks.
package hero_pkg;
   localparam int SCREEN_X_MAX = 635;
   localparam int SCREEN_Y_MAX = 475;
   localparam int CHAR_HALF_W  = 13;
   localparam int CHAR_HALF_H  = 28;
   localparam int BOMB_HALF    = 10;
   // Bomb rests on the floor line of the character sprite.
   localparam int BOMB_Y_OFF   = CHAR_HALF_H - BOMB_HALF;
   localparam int BOMB_Y_MAX   = SCREEN_Y_MAX - BOMB_HALF - 1;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FUSE1 = 2'd1,
      FUSE2 = 2'd2,
      BLAST = 2'd3
   } bomb_state_t;
endpackage

// File: rtl/bomb_ctrl_rise_detect.sv
// rise_detect: one-cycle pulse on the rising edge of an already synchronised level.
module rise_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);
   logic prev;
   always_ff @(posedge clk)
      prev <= reset_n ? din : 1'b0;
   assign rise = din & ~prev;
endmodule

// File: rtl/bomb_ctrl.sv
// bomb_ctrl: drop, fuse timing, blast display and character hit detection for the hero's bombs.
module bomb_ctrl
   import hero_pkg::*;
#(
   parameter int STEP_FRAMES  = 30,
   parameter int BLAST_FRAMES = 15,
   parameter int BOMB_STOCK   = 6,
   parameter int BLAST_RADIUS = 40
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       active,
   input  logic       level_start,
   input  logic       f_key,
   input  logic [9:0] char_pos_x,
   input  logic [9:0] char_pos_y,
   output logic [9:0] bomb_pos_x,
   output logic [9:0] bomb_pos_y,
   output logic [3:0] b_cnt,
   output logic [2:0] bombs_left,
   output logic       char_hit
);
   localparam int MAX_FRAMES = (STEP_FRAMES > BLAST_FRAMES) ? STEP_FRAMES : BLAST_FRAMES;
   localparam int CW = $clog2(MAX_FRAMES + 1);
   bomb_state_t   state;
   logic [CW-1:0] frames;
   logic          drop;
   logic [10:0]   y_off;
   logic [10:0]   dx;
   logic [10:0]   dy;
   logic [10:0]   ax;
   logic [10:0]   ay;
   logic          hit;
   logic          last_frame;
   rise_detect u_rise (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (f_key),
      .rise    (drop)
   );
   // Distances are 11-bit two's complement; the magnitude is compared unsigned.
   always_comb begin
      y_off      = {1'b0, char_pos_y} + 11'(BOMB_Y_OFF);
      dx         = {1'b0, char_pos_x} - {1'b0, bomb_pos_x};
      dy         = y_off - {1'b0, bomb_pos_y};
      ax         = dx[10] ? -dx : dx;
      ay         = dy[10] ? -dy : dy;
      hit        = (ax < 11'(BLAST_RADIUS)) && (ay < 11'(CHAR_HALF_H));
      last_frame = frames == ((state == BLAST) ? CW'(BLAST_FRAMES - 1) : CW'(STEP_FRAMES - 1));
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         frames     <= '0;
         bomb_pos_x <= '0;
         bomb_pos_y <= '0;
         bombs_left <= 3'(BOMB_STOCK);
         char_hit   <= 1'b0;
      end else begin
         char_hit <= 1'b0;
         if (level_start) begin
            state      <= IDLE;
            frames     <= '0;
            bombs_left <= 3'(BOMB_STOCK);
         end else if (state == IDLE) begin
            frames <= '0;
            if (drop && active && bombs_left != 3'd0) begin
               bomb_pos_x <= char_pos_x;
               bomb_pos_y <= (y_off > 11'(BOMB_Y_MAX)) ? 10'(BOMB_Y_MAX) : y_off[9:0];
               bombs_left <= bombs_left - 3'd1;
               state      <= FUSE1;
            end
         end else if (!active) begin
            state  <= IDLE;
            frames <= '0;
         end else if (frame_tick) begin
            if (last_frame) begin
               frames   <= '0;
               state    <= (state == FUSE1) ? FUSE2 : (state == FUSE2) ? BLAST : IDLE;
               char_hit <= (state == FUSE2) && hit;
            end else begin
               frames <= frames + CW'(1);
            end
         end
      end
   end
   assign b_cnt = {2'b00, state};
endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed scenarios checked every cycle against a phase/tick-count model of the bomb.
module tb_bomb_ctrl;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       active = 1'b0;
   logic       level_start = 1'b0;
   logic       f_key = 1'b0;
   logic [9:0] char_pos_x = 10'd300;
   logic [9:0] char_pos_y = 10'd200;
   logic [9:0] bomb_pos_x;
   logic [9:0] bomb_pos_y;
   logic [3:0] b_cnt;
   logic [2:0] bombs_left;
   logic       char_hit;
   int checks = 0;
   int failures = 0;
   int hits_seen = 0;
   bit check_en = 1'b0;
   bomb_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_tick  (frame_tick),
      .active      (active),
      .level_start (level_start),
      .f_key       (f_key),
      .char_pos_x  (char_pos_x),
      .char_pos_y  (char_pos_y),
      .bomb_pos_x  (bomb_pos_x),
      .bomb_pos_y  (bomb_pos_y),
      .b_cnt       (b_cnt),
      .bombs_left  (bombs_left),
      .char_hit    (char_hit)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Model: phase 0 = no bomb, 1/2 = fuse, 3 = blast; each phase lasts a fixed number of ticks.
   int m_phase = 0, m_ticks = 0, m_bombs = 6, m_x = 0, m_y = 0, m_hit = 0, m_prev = 0;
   int dur [4] = '{0, 30, 30, 15};
   always @(posedge clk) begin
      int press, dx, dy;
      press = (f_key && !m_prev) ? 1 : 0;
      m_prev = f_key;
      m_hit = 0;
      if (!reset_n) begin
         m_phase = 0; m_ticks = 0; m_bombs = 6; m_x = 0; m_y = 0; m_prev = 0;
      end else if (level_start) begin
         m_phase = 0; m_ticks = 0; m_bombs = 6;
      end else if (m_phase == 0) begin
         if (press == 1 && active && m_bombs > 0) begin
            m_x = char_pos_x;
            m_y = (char_pos_y + 18 > 464) ? 464 : char_pos_y + 18;
            m_bombs--;
            m_phase = 1;
            m_ticks = 0;
         end
      end else if (!active) begin
         m_phase = 0;
      end else if (frame_tick) begin
         m_ticks++;
         if (m_ticks == dur[m_phase]) begin
            if (m_phase == 2) begin
               dx = int'(char_pos_x) - m_x;
               dy = int'(char_pos_y) + 18 - m_y;
               m_hit = ((dx < 40 && dx > -40) && (dy < 28 && dy > -28)) ? 1 : 0;
            end
            m_phase = (m_phase + 1) % 4;
            m_ticks = 0;
         end
      end
   end
   always @(negedge clk) begin
      if (check_en) begin
         chk("m_b_cnt", int'(b_cnt), m_phase);
         chk("m_bombs_left", int'(bombs_left), m_bombs);
         chk("m_bomb_x", int'(bomb_pos_x), m_x);
         chk("m_bomb_y", int'(bomb_pos_y), m_y);
         chk("m_char_hit", int'(char_hit), m_hit);
         if (char_hit) hits_seen++;
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic press();
      f_key = 1'b1; cyc();
      f_key = 1'b0; cyc();
   endtask
   task automatic ticks(input int n);
      repeat (n) begin
         frame_tick = 1'b1; cyc();
         frame_tick = 1'b0; cyc();
      end
   endtask
   initial begin
      cyc(); cyc();
      check_en = 1'b1;
      chk("rst_b_cnt", int'(b_cnt), 0);
      chk("rst_bombs", int'(bombs_left), 6);
      chk("rst_pos_y", int'(bomb_pos_y), 0);
      reset_n = 1'b1; active = 1'b1; cyc();
      // Basic drop and full fuse/blast timeline
      hits_seen = 0;
      press();
      chk("t1_b_cnt", int'(b_cnt), 1);
      chk("t1_pos_x", int'(bomb_pos_x), 300);
      chk("t1_pos_y", int'(bomb_pos_y), 218);
      chk("t1_bombs", int'(bombs_left), 5);
      ticks(29); chk("t1_29", int'(b_cnt), 1);
      ticks(1);  chk("t1_30", int'(b_cnt), 2);
      ticks(30); chk("t1_60", int'(b_cnt), 3);
      chk("t1_hits", hits_seen, 1);
      ticks(14); chk("t1_74", int'(b_cnt), 3);
      ticks(1);  chk("t1_75", int'(b_cnt), 0);
      // Character walks away before the blast; then a long key hold
      hits_seen = 0;
      press(); ticks(59);
      char_pos_x = 10'd400;
      ticks(1);
      chk("t2_b_cnt", int'(b_cnt), 3);
      chk("t2_hits", hits_seen, 0);
      ticks(15);
      f_key = 1'b1; ticks(200); f_key = 1'b0; cyc();
      chk("t2_hold_bombs", int'(bombs_left), 3);
      // Stock exhaustion and reload
      level_start = 1'b1; cyc(); level_start = 1'b0; cyc();
      chk("t3_reload", int'(bombs_left), 6);
      repeat (6) begin press(); ticks(75); end
      chk("t3_empty", int'(bombs_left), 0);
      press();
      chk("t3_no_drop", int'(b_cnt), 0);
      ticks(5);
      chk("t3_still_idle", int'(b_cnt), 0);
      level_start = 1'b1; cyc(); level_start = 1'b0; cyc();
      chk("t3_restock", int'(bombs_left), 6);
      // Drop with a same-cycle tick, then abort by dropping active in FUSE2
      hits_seen = 0;
      char_pos_x = 10'd300;
      f_key = 1'b1; frame_tick = 1'b1; cyc();
      f_key = 1'b0; frame_tick = 1'b0; cyc();
      ticks(29); chk("t4_29", int'(b_cnt), 1);
      ticks(1);  chk("t4_30", int'(b_cnt), 2);
      active = 1'b0; cyc();
      chk("t4_abort", int'(b_cnt), 0);
      chk("t4_bombs", int'(bombs_left), 5);
      active = 1'b1; ticks(40);
      chk("t4_hits", hits_seen, 0);
      // Bottom clamp, then level_start colliding with a key edge
      char_pos_y = 10'd460;
      press();
      chk("t5_clamp", int'(bomb_pos_y), 464);
      level_start = 1'b1; f_key = 1'b1; cyc();
      level_start = 1'b0; cyc(); f_key = 1'b0; cyc();
      chk("t5_idle", int'(b_cnt), 0);
      chk("t5_bombs", int'(bombs_left), 6);
      // Reset during the blast
      press(); ticks(60);
      chk("t6_blast", int'(b_cnt), 3);
      hits_seen = 0;
      reset_n = 1'b0; cyc();
      chk("t6_b_cnt", int'(b_cnt), 0);
      chk("t6_bombs", int'(bombs_left), 6);
      chk("t6_pos_x", int'(bomb_pos_x), 0);
      chk("t6_hit", int'(char_hit), 0);
      reset_n = 1'b1; cyc(); cyc();
      chk("t6_hits", hits_seen, 0);
      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
